// File: rtl/bin_to_gray_pkg.sv
// Shared helpers for the binary/Gray converter: generic encode/decode and popcount
// over a maximum-width word, plus the default converter width.
package bin_to_gray_pkg;

  localparam int MAX_W = 32;
  localparam int DEF_W = 4;

  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t bin2gray(word_t b);
    return b ^ (b >> 1);
  endfunction

  // Narrower values are zero-extended, so the prefix XOR from the top is still exact.
  function automatic word_t gray2bin(word_t g);
    word_t b;
    logic  acc;
    b   = '0;
    acc = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(word_t v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bin_to_gray_gray_to_bin.sv
// Combinational WIDTH-generic Gray-to-binary decoder: each binary bit is the XOR
// of all Gray bits at or above it.
module gray_to_bin
  import bin_to_gray_pkg::*;
#(
  parameter int WIDTH = DEF_W
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/bin_to_gray.sv
// Registered binary-to-Gray converter with round-trip decode and a single-step
// monitor that flags unit binary steps whose Gray codes differ in other than one bit.
module bin_to_gray
  import bin_to_gray_pkg::*;
#(
  parameter int WIDTH = DEF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_back,
  output logic             step_err
);

  logic [WIDTH-1:0] gray_p0;
  logic [WIDTH-1:0] bin_back_p0;
  word_t            diff_p0;
  logic             unit_step_p0;
  logic             err_p0;

  logic [WIDTH-1:0] gray_p1;
  logic [WIDTH-1:0] bin_back_p1;
  logic             vld_p1;
  logic             err_p1;

  // History of the last accepted sample; gray_p1 doubles as the previous Gray code.
  logic [WIDTH-1:0] prev_bin;
  logic             has_prev;

  // ---- stage p0: encode, decode and step check (combinational) ----
  always_comb begin
    gray_p0 = bin ^ (bin >> 1);
  end

  gray_to_bin #(
    .WIDTH(WIDTH)
  ) u_gray_to_bin (
    .gray(gray_p0),
    .bin (bin_back_p0)
  );

  always_comb begin
    diff_p0      = word_t'(gray_p0 ^ gray_p1);
    unit_step_p0 = (bin == prev_bin + WIDTH'(1)) || (bin == prev_bin - WIDTH'(1));
    err_p0       = in_valid && has_prev && unit_step_p0 && (popcount(diff_p0) != 6'd1);
  end

  // ---- stage p1: output and history registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      err_p1      <= 1'b0;
      gray_p1     <= '0;
      bin_back_p1 <= '0;
      prev_bin    <= '0;
      has_prev    <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      err_p1 <= err_p0;
      if (in_valid) begin
        gray_p1     <= gray_p0;
        bin_back_p1 <= bin_back_p0;
        prev_bin    <= bin;
        has_prev    <= 1'b1;
      end
    end
  end

  assign out_valid = vld_p1;
  assign gray      = gray_p1;
  assign bin_back  = bin_back_p1;
  assign step_err  = err_p1;

endmodule

// File: tb/tb_bin_to_gray.sv
// Scoreboard bench for bin_to_gray: a reflected-code reference model feeds expectation
// queues, and negedge monitors compare the WIDTH=4 instance and WIDTH=1/8/32 instances.
module tb_bin_to_gray;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid;
  logic [3:0] bin;
  logic       out_valid, step_err;
  logic [3:0] gray, bin_back;

  bin_to_gray #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bin(bin),
    .out_valid(out_valid), .gray(gray), .bin_back(bin_back), .step_err(step_err)
  );

  logic        xv;
  logic [31:0] xb;
  logic        xo1, xo8, xo32, xe1, xe8, xe32;
  logic [0:0]  xg1, xbb1;
  logic [7:0]  xg8, xbb8;
  logic [31:0] xg32, xbb32;

  bin_to_gray #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(xv), .bin(xb[0:0]),
    .out_valid(xo1), .gray(xg1), .bin_back(xbb1), .step_err(xe1)
  );
  bin_to_gray #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(xv), .bin(xb[7:0]),
    .out_valid(xo8), .gray(xg8), .bin_back(xbb8), .step_err(xe8)
  );
  bin_to_gray #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(xv), .bin(xb),
    .out_valid(xo32), .gray(xg32), .bin_back(xbb32), .step_err(xe32)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // n-th codeword of the reflected binary code: the upper half of a w-bit list is the
  // mirrored (w-1)-bit list with the top bit set.
  function automatic longint unsigned refl(input longint unsigned n, input int w);
    longint unsigned g, half, i;
    g = 0;
    i = n & wmask(w);
    for (int k = w; k >= 1; k--) begin
      half = 64'd1 << (k - 1);
      if (i >= half) begin
        g = g | half;
        i = (half << 1) - 64'd1 - i;
      end
    end
    return g;
  endfunction

  function automatic bit exp_err(input longint unsigned b, input longint unsigned p,
                                 input bit hp, input int w);
    bit unit;
    unit = (((b - p) & wmask(w)) == 1) || (((p - b) & wmask(w)) == 1);
    return hp && unit && ($countones(refl(b, w) ^ refl(p, w)) != 1);
  endfunction

  typedef struct packed {logic [3:0] g; logic [3:0] b; logic e;} exp4_t;
  typedef struct packed {longint unsigned b; logic [2:0] e;} expx_t;

  exp4_t q4[$];
  expx_t qx[$];

  longint unsigned p4, px;
  bit              hp4, hpx;
  logic [3:0]      hold_g, hold_b;

  task automatic push4(input longint unsigned b);
    exp4_t e;
    e.g = 4'(refl(b, 4));
    e.b = 4'(b);
    e.e = exp_err(b, p4, hp4, 4);
    q4.push_back(e);
    p4  = b & wmask(4);
    hp4 = 1'b1;
  endtask

  task automatic send4(input int b);
    @(posedge clk);
    #1;
    bin      = 4'(b);
    in_valid = 1'b1;
    push4(longint'(b));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      xv       = 1'b0;
    end
  endtask

  task automatic send_rand();
    logic [31:0] v;
    expx_t       e;
    int          sel;
    sel = $urandom_range(0, 3);
    if (sel == 0)      v = 32'(px + 1);
    else if (sel == 1) v = 32'(px - 1);
    else               v = $urandom();
    @(posedge clk);
    #1;
    bin      = v[3:0];
    in_valid = 1'b1;
    xb       = v;
    xv       = 1'b1;
    push4(longint'(v));
    e.b    = longint'(v);
    e.e[0] = exp_err(longint'(v), px, hpx, 1);
    e.e[1] = exp_err(longint'(v), px, hpx, 8);
    e.e[2] = exp_err(longint'(v), px, hpx, 32);
    qx.push_back(e);
    px  = longint'(v);
    hpx = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    xv       = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_async", {out_valid, gray, bin_back, step_err}, 64'd0);
    chk("reset_async_x", {xo1, xo8, xo32, xg8, xbb8, xg32, xbb32}, 64'd0);
    q4.delete();
    qx.delete();
    hp4    = 1'b0;
    hpx    = 1'b0;
    hold_g = '0;
    hold_b = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  exp4_t me;
  expx_t mx;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_out", {out_valid, gray, bin_back, step_err}, 64'd0);
    end else if (out_valid) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got out_valid=1 gray=%0h, expected no output", gray);
      end else begin
        me = q4.pop_front();
        chk("gray", gray, me.g);
        chk("bin_back", bin_back, me.b);
        chk("step_err", step_err, me.e);
        hold_g = me.g;
        hold_b = me.b;
      end
    end else begin
      chk("gap_gray", gray, hold_g);
      chk("gap_bin_back", bin_back, hold_b);
      chk("gap_step_err", step_err, 64'd0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("x_valid_agree", {xo1, xo8}, {xo32, xo32});
      if (xo32) begin
        if (qx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL x_unexpected_out: got gray32=%0h, expected no output", xg32);
        end else begin
          mx = qx.pop_front();
          chk("w1_gray", xg1, refl(mx.b, 1));
          chk("w1_bin_back", xbb1, mx.b & wmask(1));
          chk("w8_gray", xg8, refl(mx.b, 8));
          chk("w8_bin_back", xbb8, mx.b & wmask(8));
          chk("w32_gray", xg32, refl(mx.b, 32));
          chk("w32_bin_back", xbb32, mx.b & wmask(32));
          chk("x_step_err", {xe1, xe8, xe32}, {mx.e[0], mx.e[1], mx.e[2]});
        end
      end else begin
        chk("x_gap_step_err", {xe1, xe8, xe32}, 64'd0);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    bin      = '0;
    xv       = 1'b0;
    xb       = '0;
    p4       = 0;
    px       = 0;
    hp4      = 1'b0;
    hpx      = 1'b0;
    hold_g   = '0;
    hold_b   = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Full up-count sweep, then wrap 15->0 and down-step 0->15.
    for (int i = 0; i < 16; i++) send4(i);
    send4(0);
    send4(15);
    idle(1);

    // Gap: gray must hold the code for 5 while out_valid is low.
    send4(5);
    idle(2);
    send4(6);
    idle(1);

    // Non-unit jump never flags.
    send4(3);
    send4(9);
    idle(1);

    // Reset mid-sweep; the first sample after release is a fresh start.
    for (int i = 0; i < 6; i++) send4(i);
    do_reset();
    send4(6);
    send4(7);
    idle(1);

    for (int i = 0; i < 10000; i++) send_rand();
    idle(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain_main", q4.size(), 64'd0);
    chk("drain_x", qx.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
